// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment constants and hex-digit glyph table for seg7_array
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] glyph(input logic [3:0] n);
    return GLYPHS[n];
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: 4-bit to active-low 7-segment decode, blank when not enabled
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       en,
  output logic [6:0] seg
);
  assign seg = en ? glyph(nib) : SEG_BLANK;
endmodule

// File: rtl/seg7_array.sv
// seg7_array: latched multi-digit 7-segment driver with enable, LZS, blink and dash modes
module seg7_array
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   val,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lzs,
  input  logic                  err,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  upd
);
  localparam int CW = $clog2(BLINK_DIV);
  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0] en_q, blink_q;
  logic lzs_q, err_q, ld_q, phase, wrap;
  logic [CW-1:0] cnt;
  logic [3:0] hi;
  logic [7*DIGITS-1:0] seg;
  always_comb begin
    hi = '0;
    for (int i = 0; i < DIGITS; i++) hi = (val_q[4*i+:4] != 4'h0) ? 4'(i) : hi;
  end
  assign wrap = (cnt == CW'(BLINK_DIV - 1));
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic on;
    logic [6:0] glyph_seg;
    assign on = en_q[d] && !(lzs_q && (4'(d) > hi)) && !(blink_q[d] && !phase);
    seg7_glyph u_glyph (.nib(val_q[4*d+:4]), .en(on), .seg(glyph_seg));
    assign seg[7*d+:7] = (en_q[d] && err_q) ? SEG_DASH : glyph_seg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      en_q <= '0;
      blink_q <= '0;
      lzs_q <= 1'b0;
      err_q <= 1'b0;
      ld_q <= 1'b0;
      upd <= 1'b0;
      cnt <= '0;
      phase <= 1'b1;
      hex <= '1;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      phase <= phase ^ wrap;
      if (load) begin
        val_q <= val;
        en_q <= en_mask;
        blink_q <= blink_mask;
        lzs_q <= lzs;
        err_q <= err;
      end
      ld_q <= load;
      upd <= ld_q;
      hex <= seg;
    end
  end
endmodule

// File: tb/tb_seg7_array.sv
// tb_seg7_array: directed self-checking bench for seg7_array (DIGITS=4, BLINK_DIV=4)
module tb_seg7_array;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, lzs = 1'b0, err = 1'b0, upd;
  logic [15:0] val = '0;
  logic [3:0] en_mask = '0, blink_mask = '0;
  logic [27:0] hex;
  logic [6:0] d0 [16];
  int n_cmp = 0, n_bad = 0;

  seg7_array #(.DIGITS(4), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .val(val), .en_mask(en_mask),
    .blink_mask(blink_mask), .lzs(lzs), .err(err), .hex(hex), .upd(upd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] b,
                         input logic z, input logic r);
    val = v; en_mask = e; blink_mask = b; lzs = z; err = r; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  initial begin
    // reset wins over a simultaneous load
    load = 1'b1; val = 16'h12AF; en_mask = 4'hF;
    tick();
    chk("rst_hex", hex, 28'hFFFFFFF);
    chk("rst_upd", 28'(upd), 28'd0);
    rst = 1'b0; load = 1'b0;
    tick();
    chk("rst_hold_hex", hex, 28'hFFFFFFF);
    chk("rst_hold_upd", 28'(upd), 28'd0);

    do_load(16'h12AF, 4'hF, 4'h0, 1'b0, 1'b0);
    chk("basic_hex", hex, {7'h79, 7'h24, 7'h08, 7'h0E});
    chk("basic_upd", 28'(upd), 28'd1);
    tick();
    chk("basic_upd_end", 28'(upd), 28'd0);
    chk("basic_hold", hex, {7'h79, 7'h24, 7'h08, 7'h0E});

    do_load(16'h0050, 4'hF, 4'h0, 1'b1, 1'b0);
    chk("lzs_50", hex, {7'h7F, 7'h7F, 7'h12, 7'h40});
    do_load(16'h0000, 4'hF, 4'h0, 1'b1, 1'b0);
    chk("lzs_0", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    do_load(16'h0050, 4'hC, 4'h0, 1'b1, 1'b0);
    chk("lzs_en_indep", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    do_load(16'h0A05, 4'hF, 4'h0, 1'b1, 1'b0);
    chk("lzs_inner_zero", hex, {7'h7F, 7'h08, 7'h40, 7'h12});

    do_load(16'h1234, 4'hF, 4'h1, 1'b0, 1'b0);
    chk("blink_upd", 28'(upd), 28'd1);
    for (int k = 0; k < 16; k++) begin
      tick();
      d0[k] = hex[6:0];
      chk($sformatf("blink_steady_%0d", k), 28'(hex[27:7]), 28'({7'h79, 7'h24, 7'h30}));
      chk($sformatf("blink_no_upd_%0d", k), 28'(upd), 28'd0);
    end
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("blink_legal_%0d", k), 28'(d0[k] == 7'h7F || d0[k] == 7'h19), 28'd1);
      chk($sformatf("blink_half_%0d", k), 28'(d0[k] != d0[k+4]), 28'd1);
    end

    do_load(16'h0000, 4'h6, 4'hF, 1'b1, 1'b1);
    chk("err_hex", hex, {7'h7F, 7'h3F, 7'h3F, 7'h7F});
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("err_steady_%0d", k), hex, {7'h7F, 7'h3F, 7'h3F, 7'h7F});
    end

    // back-to-back loads
    val = 16'h12AF; en_mask = 4'hF; blink_mask = 4'h0; lzs = 1'b0; err = 1'b0; load = 1'b1;
    tick();
    val = 16'h0050; lzs = 1'b1;
    tick();
    load = 1'b0;
    chk("b2b_a_hex", hex, {7'h79, 7'h24, 7'h08, 7'h0E});
    chk("b2b_a_upd", 28'(upd), 28'd1);
    tick();
    chk("b2b_b_hex", hex, {7'h7F, 7'h7F, 7'h12, 7'h40});
    chk("b2b_b_upd", 28'(upd), 28'd1);
    tick();
    chk("b2b_upd_end", 28'(upd), 28'd0);
    rst = 1'b1;
    tick();
    chk("midrst_hex", hex, 28'hFFFFFFF);
    chk("midrst_upd", 28'(upd), 28'd0);
    rst = 1'b0;
    tick();
    chk("midrst_hold", hex, 28'hFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
